ma_lsu: RTL and testbench

//  MA-stage load/store unit; the initiator side of the byte-enabled 1R1W data RAM.

---
 rtl/ma_lsu.sv | 116 +++++++++++
 tb/tb_ma_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ma_lsu.sv
// MA-stage load/store unit: drives a byte-enabled 1R1W data RAM and returns one
// aligned, extended response per request through a one-entry valid/ready register.
module ma_lsu #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_unsigned,
    input  logic [31:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    input  logic [4:0]    i_req_rd,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_rdata,
    output logic [4:0]    o_rsp_rd,
    output logic          o_rsp_is_load,
    output logic          o_rsp_err,
    output logic [AW-1:0] o_ram_radr,
    input  logic [31:0]   i_ram_rdata,
    output logic [AW-1:0] o_ram_wadr,
    output logic [31:0]   o_ram_wdata,
    output logic [3:0]    o_ram_wen
);

    logic          r_rsp_valid;
    logic [4:0]    r_rsp_rd;
    logic          r_rsp_is_load;
    logic          r_rsp_err;
    logic [AW-1:0] r_hold_adr;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_unsigned;

    logic          w_acc;
    logic          w_err;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign o_req_ready = !i_rst && (!r_rsp_valid || i_rsp_ready);
    assign w_acc       = i_req_valid && o_req_ready;

    assign w_err = (i_req_size == 2'b11)
                || (i_req_size == 2'b01 && i_req_addr[0])
                || (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00)
                || (i_req_addr[31:AW+2] != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rd      <= '0;
            r_rsp_is_load <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_hold_adr    <= '0;
            r_off         <= '0;
            r_size        <= '0;
            r_unsigned    <= 1'b0;
        end else if (w_acc) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rd      <= i_req_rd;
            r_rsp_is_load <= !i_req_we;
            r_rsp_err     <= w_err;
            r_hold_adr    <= i_req_addr[AW+1:2];
            r_off         <= i_req_addr[1:0];
            r_size        <= i_req_size;
            r_unsigned    <= i_req_unsigned;
        end else if (i_rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    // Re-presenting the held address during a stall keeps the RAM read data stable.
    assign o_ram_radr = w_acc ? i_req_addr[AW+1:2] : r_hold_adr;
    assign o_ram_wadr = i_req_addr[AW+1:2];

    always_comb begin
        o_ram_wdata = i_req_wdata;
        o_ram_wen   = 4'b0000;
        case (i_req_size)
            2'b00:   o_ram_wdata = {4{i_req_wdata[7:0]}};
            2'b01:   o_ram_wdata = {2{i_req_wdata[15:0]}};
            default: o_ram_wdata = i_req_wdata;
        endcase
        if (w_acc && i_req_we && !w_err) begin
            case (i_req_size)
                2'b00:   o_ram_wen = 4'b0001 << i_req_addr[1:0];
                2'b01:   o_ram_wen = i_req_addr[1] ? 4'b1100 : 4'b0011;
                2'b10:   o_ram_wen = 4'b1111;
                default: o_ram_wen = 4'b0000;
            endcase
        end
    end

    assign w_byte = i_ram_rdata[{r_off, 3'b000} +: 8];
    assign w_half = i_ram_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        o_rsp_rdata = '0;
        if (r_rsp_valid && r_rsp_is_load && !r_rsp_err) begin
            case (r_size)
                2'b00:   o_rsp_rdata = {{24{!r_unsigned && w_byte[7]}}, w_byte};
                2'b01:   o_rsp_rdata = {{16{!r_unsigned && w_half[15]}}, w_half};
                default: o_rsp_rdata = i_ram_rdata;
            endcase
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rd      = r_rsp_rd;
    assign o_rsp_is_load = r_rsp_is_load;
    assign o_rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_ma_lsu.sv
// Vector-driven bench for ma_lsu with a behavioural byte-enabled RAM whose
// read address is registered and whose write lands before the array read.
module tb_ma_lsu;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic [4:0]    req_rd;
    logic          rsp_valid, rsp_ready, rsp_is_load, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [4:0]    rsp_rd;
    logic [AW-1:0] ram_radr, ram_wadr;
    logic [31:0]   ram_rdata, ram_wdata;
    logic [3:0]    ram_wen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ma_lsu #(.AW(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_rd(req_rd),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_rd(rsp_rd), .o_rsp_is_load(rsp_is_load), .o_rsp_err(rsp_err),
        .o_ram_radr(ram_radr), .i_ram_rdata(ram_rdata),
        .o_ram_wadr(ram_wadr), .o_ram_wdata(ram_wdata), .o_ram_wen(ram_wen)
    );

    // RAM model
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_radr_q = '0;
    initial for (int k = 0; k < (1 << AW); k++) mem[k] = 32'h0;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_wadr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_radr_q <= ram_radr;
    end
    assign ram_rdata = mem[ram_radr_q];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ew,
                       input logic [31:0] ewd, input logic ee, input logic [31:0] erd);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.e_wen = ew; v.e_wdata = ewd; v.e_err = ee; v.e_rdata = erd;
        vt.push_back(v);
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        //  we  sz     u  addr          wdata         wen      ram_wdata     err  rdata
        add(1, 2'b10, 0, 32'h0000_0004, 32'h0,         4'b1111, 32'h0,         0, 32'h0);
        add(1, 2'b00, 0, 32'h0000_0005, 32'h1234_56A7, 4'b0010, 32'hA7A7_A7A7, 0, 32'h0);
        add(0, 2'b00, 0, 32'h0000_0005, 32'h0,         4'b0000, 32'h0,         0, 32'hFFFF_FFA7);
        add(0, 2'b00, 1, 32'h0000_0005, 32'h0,         4'b0000, 32'h0,         0, 32'h0000_00A7);
        add(0, 2'b10, 0, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         0, 32'h0000_A700);
        add(1, 2'b01, 0, 32'h0000_0006, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0);
        add(0, 2'b01, 0, 32'h0000_0006, 32'h0,         4'b0000, 32'h0,         0, 32'hFFFF_BEEF);
        add(0, 2'b01, 1, 32'h0000_0006, 32'h0,         4'b0000, 32'h0,         0, 32'h0000_BEEF);
        add(0, 2'b00, 0, 32'h0000_0007, 32'h0,         4'b0000, 32'h0,         0, 32'hFFFF_FFBE);
        add(0, 2'b01, 0, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         0, 32'hFFFF_A700);
        add(0, 2'b10, 0, 32'h0000_0002, 32'h0,         4'b0000, 32'h0,         1, 32'h0);
        add(1, 2'b01, 0, 32'h0000_0003, 32'h0000_1111, 4'b0000, 32'h1111_1111, 1, 32'h0);
        add(0, 2'b11, 0, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         1, 32'h0);
        add(1, 2'b10, 0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF, 1, 32'h0);
        add(1, 2'b10, 0, 32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 0, 32'h0);
        add(0, 2'b10, 0, 32'h0000_0FFC, 32'h0,         4'b0000, 32'h0,         0, 32'hCAFE_F00D);
        add(1, 2'b00, 0, 32'h0000_0008, 32'h0000_0080, 4'b0001, 32'h8080_8080, 0, 32'h0);
        add(0, 2'b00, 0, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         0, 32'hFFFF_FF80);
        add(0, 2'b00, 1, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         0, 32'h0000_0080);
        add(0, 2'b10, 0, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         0, 32'hBEEF_A700);
        add(0, 2'b10, 0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0,         0, 32'h0);

        // Reset with a legal store presented: nothing may be accepted or written.
        rst = 1'b1; rsp_ready = 1'b1;
        drive(1, 1, 2'b10, 0, 32'h0000_0010, 32'h1111_2222, 5'd0);
        step(); step();
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_ram_wen",   {28'b0, ram_wen}, 32'h0);
        chk("rst_radr",      {22'b0, ram_radr}, 32'h0);
        chk("rst_rsp_rd",    {27'b0, rsp_rd}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);

        // Back-to-back table: request i is checked while response i-1 is checked.
        for (int i = 0; i <= vt.size(); i++) begin
            if (i < vt.size())
                drive(1, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, 5'(i));
            else
                drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
            @(negedge clk);
            if (i < vt.size()) begin
                chk($sformatf("v%0d_ready", i), {31'b0, req_ready}, 32'h1);
                chk($sformatf("v%0d_wen", i), {28'b0, ram_wen}, {28'b0, vt[i].e_wen});
                chk($sformatf("v%0d_wdata", i), ram_wdata, vt[i].e_wdata);
                chk($sformatf("v%0d_wadr", i), {22'b0, ram_wadr}, {22'b0, vt[i].addr[11:2]});
                chk($sformatf("v%0d_radr", i), {22'b0, ram_radr}, {22'b0, vt[i].addr[11:2]});
            end
            if (i > 0) begin
                chk($sformatf("v%0d_rsp_valid", i-1), {31'b0, rsp_valid}, 32'h1);
                chk($sformatf("v%0d_rsp_rd", i-1), {27'b0, rsp_rd}, 32'(i-1));
                chk($sformatf("v%0d_is_load", i-1), {31'b0, rsp_is_load}, {31'b0, !vt[i-1].we});
                chk($sformatf("v%0d_err", i-1), {31'b0, rsp_err}, {31'b0, vt[i-1].e_err});
                chk($sformatf("v%0d_rdata", i-1), rsp_rdata, vt[i-1].e_rdata);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_rsp_valid", {31'b0, rsp_valid}, 32'h0);

        // Stall: LW held for 3 cycles while a store waits at the request port.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive(1, 0, 2'b10, 0, 32'h0000_0004, 32'h0, 5'd7);
        step();
        drive(1, 1, 2'b10, 0, 32'h0000_0008, 32'h0000_0055, 5'd8);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_req_ready", c), {31'b0, req_ready}, 32'h0);
            chk($sformatf("stall%0d_radr", c), {22'b0, ram_radr}, 32'h1);
            chk($sformatf("stall%0d_rdata", c), rsp_rdata, 32'hBEEF_A700);
            chk($sformatf("stall%0d_wen", c), {28'b0, ram_wen}, 32'h0);
            chk($sformatf("stall%0d_rd", c), {27'b0, rsp_rd}, 32'd7);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("unstall_req_ready", {31'b0, req_ready}, 32'h1);
        chk("unstall_wen", {28'b0, ram_wen}, 32'hF);
        chk("unstall_rdata", rsp_rdata, 32'hBEEF_A700);
        @(posedge clk); #1;
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        chk("st_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("st_rsp_rd", {27'b0, rsp_rd}, 32'd8);
        chk("st_is_load", {31'b0, rsp_is_load}, 32'h0);
        @(posedge clk); #1;

        // Reset during a stall discards the pending response and blocks a store.
        rsp_ready = 1'b0;
        drive(1, 0, 2'b10, 0, 32'h0000_0004, 32'h0, 5'd9);
        step();
        drive(1, 1, 2'b10, 0, 32'h0000_0008, 32'h0000_0099, 5'd10);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_req_ready", {31'b0, req_ready}, 32'h0);
        chk("rst2_wen", {28'b0, ram_wen}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst2_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst2_wen_held", {28'b0, ram_wen}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; rsp_ready = 1'b1;
        drive(1, 0, 2'b10, 0, 32'h0000_0008, 32'h0, 5'd11);
        step();
        drive(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'h1);
        chk("post_rst_rdata", rsp_rdata, 32'h0000_0055);
        chk("post_rst_rd", {27'b0, rsp_rd}, 32'd11);
        chk("post_rst_err", {31'b0, rsp_err}, 32'h0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
